// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;

  typedef enum logic [1:0] {
    StRun     = ST_RUN,
    StMemWait = ST_MEMWAIT,
    StErr     = ST_ERR
  } state_e;

  // PC source select codes
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_JAL = 2'b11;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage fields in, pipeline-register controls and status out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] IDrs;
  logic [REG_ADDR_W-1:0] IDrt;
  logic                  IDusesRt;
  logic                  EXmemread;
  logic [REG_ADDR_W-1:0] EXRegDst;
  logic                  Mbranch;
  logic                  MAluZero;
  logic [1:0]            Mcntrljr;
  logic                  Mcntrljald;
  logic                  Mmemread;
  logic                  Mmemwrite;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  IFIDWrite;
  logic                  IDEXWrite;
  logic                  EXMWrite;
  logic                  IFIDFlush;
  logic                  IDEXFlush;
  logic                  EXMFlush;
  logic [1:0]            PCSrcSel;
  logic [CNT_W-1:0]      StallCount;
  logic [CNT_W-1:0]      FlushCount;
  logic                  MemTimeout;

  // Datapath side: supplies stage fields, consumes controls
  modport master (
    output IDrs, IDrt, IDusesRt, EXmemread, EXRegDst, Mbranch, MAluZero, Mcntrljr,
           Mcntrljald, Mmemread, Mmemwrite, MemReady,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMWrite, IFIDFlush, IDEXFlush, EXMFlush,
           PCSrcSel, StallCount, FlushCount, MemTimeout
  );

  // Controller side
  modport slave (
    input  IDrs, IDrt, IDusesRt, EXmemread, EXRegDst, Mbranch, MAluZero, Mcntrljr,
           Mcntrljald, Mmemread, Mmemwrite, MemReady,
    output PCWrite, IFIDWrite, IDEXWrite, EXMWrite, IFIDFlush, IDEXFlush, EXMFlush,
           PCSrcSel, StallCount, FlushCount, MemTimeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Count up on inc, hold at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: load-use bubbles, MEM-stage
// redirects and data-memory waits with a timeout trap.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             tout_q, tout_d;

  logic       mem_busy, redirect, load_use, eval_run;
  logic       stall_inc, flush_inc;
  logic       pc_write, ifid_write, idex_write, exm_write;
  logic       ifid_flush, idex_flush, exm_flush;
  logic [1:0] pcsrc;

  assign mem_busy = (bus.Mmemread | bus.Mmemwrite) & ~bus.MemReady;
  assign redirect = (bus.Mcntrljr != 2'b00) | bus.Mcntrljald | (bus.Mbranch & bus.MAluZero);
  assign load_use = bus.EXmemread && (bus.EXRegDst != REG_ADDR_W'(0)) &&
                    ((bus.EXRegDst == bus.IDrs) ||
                     (bus.IDusesRt && (bus.EXRegDst == bus.IDrt)));

  // Next state and Mealy controls from state and current stage fields
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    tout_d     = tout_q;
    eval_run   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    idex_write = 1'b0;
    exm_write  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exm_flush  = 1'b0;
    pcsrc      = PCSRC_SEQ;

    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          stall_inc = 1'b1;
          state_d   = StMemWait;
          wait_d    = WaitW'(1);
        end else begin
          eval_run = 1'b1;
        end
      end
      StMemWait: begin
        if (bus.MemReady) begin
          // Access completes: the frozen fields are evaluated now
          eval_run = 1'b1;
          state_d  = StRun;
          wait_d   = '0;
        end else begin
          stall_inc = 1'b1;
          if (wait_q == WaitLast) begin
            tout_d  = 1'b1;
            state_d = StErr;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      StErr: ;
      default: state_d = StRun;
    endcase

    if (eval_run) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      idex_write = 1'b1;
      exm_write  = 1'b1;
      if (redirect) begin
        // Redirect squashes younger work, so a coincident load-use is moot
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exm_flush  = 1'b1;
        flush_inc  = 1'b1;
        if (bus.Mcntrljr != 2'b00) pcsrc = PCSRC_JR;
        else if (bus.Mcntrljald)   pcsrc = PCSRC_JAL;
        else                       pcsrc = PCSRC_BR;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end

    // Hold everything quiet while reset is asserted
    if (!Reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      exm_write  = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      exm_flush  = 1'b0;
      pcsrc      = PCSRC_SEQ;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRun;
      wait_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tout_q  <= tout_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .inc_i   (stall_inc),
    .count_o (bus.StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .inc_i   (flush_inc),
    .count_o (bus.FlushCount)
  );

  assign bus.PCWrite    = pc_write;
  assign bus.IFIDWrite  = ifid_write;
  assign bus.IDEXWrite  = idex_write;
  assign bus.EXMWrite   = exm_write;
  assign bus.IFIDFlush  = ifid_flush;
  assign bus.IDEXFlush  = idex_flush;
  assign bus.EXMFlush   = exm_flush;
  assign bus.PCSrcSel   = pcsrc;
  assign bus.MemTimeout = tout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchecks = 0;
  int   nfail = 0;

  // {PCWrite, IFIDWrite, IDEXWrite, EXMWrite, IFIDFlush, IDEXFlush, EXMFlush, PCSrcSel}
  localparam logic [8:0] CtlOff  = 9'b0000_000_00;
  localparam logic [8:0] CtlRun  = 9'b1111_000_00;
  localparam logic [8:0] CtlLu   = 9'b0011_010_00;
  localparam logic [8:0] CtlBr   = 9'b1111_111_01;
  localparam logic [8:0] CtlJr   = 9'b1111_111_10;
  localparam logic [8:0] CtlJal  = 9'b1111_111_11;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16), .MEM_TIMEOUT(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] ctl;
  assign ctl = {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMWrite,
                bus.IFIDFlush, bus.IDEXFlush, bus.EXMFlush, bus.PCSrcSel};

  task automatic idle();
    bus.IDrs = 5'd0; bus.IDrt = 5'd0; bus.IDusesRt = 1'b0;
    bus.EXmemread = 1'b0; bus.EXRegDst = 5'd0;
    bus.Mbranch = 1'b0; bus.MAluZero = 1'b0; bus.Mcntrljr = 2'd0; bus.Mcntrljald = 1'b0;
    bus.Mmemread = 1'b0; bus.Mmemwrite = 1'b0; bus.MemReady = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #2;
    nchecks++; if (ctl !== CtlOff) begin nfail++; $display("FAIL rst_ctl got=%b want=%b", ctl, CtlOff); end
    nchecks++; if (bus.StallCount !== 16'd0) begin nfail++; $display("FAIL rst_stall got=%0d want=0", bus.StallCount); end
    nchecks++; if (bus.FlushCount !== 16'd0) begin nfail++; $display("FAIL rst_flush got=%0d want=0", bus.FlushCount); end
    nchecks++; if (bus.MemTimeout !== 1'b0) begin nfail++; $display("FAIL rst_tout got=%b want=0", bus.MemTimeout); end
    tick();
    rst = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL run_idle got=%b want=%b", ctl, CtlRun); end
    tick();
  endtask

  task automatic test_load_use();
    // rs hazard
    bus.EXmemread = 1'b1; bus.EXRegDst = 5'd8; bus.IDrs = 5'd8; bus.IDrt = 5'd3;
    #1;
    nchecks++; if (ctl !== CtlLu) begin nfail++; $display("FAIL lu_rs_ctl got=%b want=%b", ctl, CtlLu); end
    tick();
    nchecks++; if (bus.StallCount !== 16'd1) begin nfail++; $display("FAIL lu_rs_cnt got=%0d want=1", bus.StallCount); end
    idle();
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL lu_after got=%b want=%b", ctl, CtlRun); end
    // destination $0 never hazards
    bus.EXmemread = 1'b1; bus.EXRegDst = 5'd0; bus.IDrs = 5'd0;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL lu_r0_ctl got=%b want=%b", ctl, CtlRun); end
    tick();
    nchecks++; if (bus.StallCount !== 16'd1) begin nfail++; $display("FAIL lu_r0_cnt got=%0d want=1", bus.StallCount); end
    // rt hazard only when rt is read
    bus.EXRegDst = 5'd5; bus.IDrs = 5'd2; bus.IDrt = 5'd5; bus.IDusesRt = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlLu) begin nfail++; $display("FAIL lu_rt_ctl got=%b want=%b", ctl, CtlLu); end
    tick();
    nchecks++; if (bus.StallCount !== 16'd2) begin nfail++; $display("FAIL lu_rt_cnt got=%0d want=2", bus.StallCount); end
    bus.IDusesRt = 1'b0;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL lu_nort_ctl got=%b want=%b", ctl, CtlRun); end
    tick();
    nchecks++; if (bus.StallCount !== 16'd2) begin nfail++; $display("FAIL lu_nort_cnt got=%0d want=2", bus.StallCount); end
    idle();
  endtask

  task automatic test_branch();
    bus.Mbranch = 1'b1; bus.MAluZero = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlBr) begin nfail++; $display("FAIL br_ctl got=%b want=%b", ctl, CtlBr); end
    tick();
    nchecks++; if (bus.FlushCount !== 16'd1) begin nfail++; $display("FAIL br_cnt got=%0d want=1", bus.FlushCount); end
    bus.MAluZero = 1'b0;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL br_nt_ctl got=%b want=%b", ctl, CtlRun); end
    tick();
    nchecks++; if (bus.FlushCount !== 16'd1) begin nfail++; $display("FAIL br_nt_cnt got=%0d want=1", bus.FlushCount); end
    idle();
  endtask

  task automatic test_priority();
    bus.Mcntrljr = 2'd3; bus.Mcntrljald = 1'b1; bus.Mbranch = 1'b1; bus.MAluZero = 1'b1;
    bus.EXmemread = 1'b1; bus.EXRegDst = 5'd8; bus.IDrs = 5'd8;
    #1;
    nchecks++; if (ctl !== CtlJr) begin nfail++; $display("FAIL pri_ctl got=%b want=%b", ctl, CtlJr); end
    tick();
    nchecks++; if (bus.FlushCount !== 16'd2) begin nfail++; $display("FAIL pri_flush got=%0d want=2", bus.FlushCount); end
    nchecks++; if (bus.StallCount !== 16'd2) begin nfail++; $display("FAIL pri_stall got=%0d want=2", bus.StallCount); end
    idle();
    bus.Mcntrljald = 1'b1; bus.Mbranch = 1'b1; bus.MAluZero = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlJal) begin nfail++; $display("FAIL jal_ctl got=%b want=%b", ctl, CtlJal); end
    tick();
    nchecks++; if (bus.FlushCount !== 16'd3) begin nfail++; $display("FAIL jal_cnt got=%0d want=3", bus.FlushCount); end
    idle();
  endtask

  task automatic test_memwait();
    do_reset();
    bus.Mmemread = 1'b1; bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchecks++; if (ctl !== CtlOff) begin nfail++; $display("FAIL mw_ctl[%0d] got=%b want=%b", i, ctl, CtlOff); end
      tick();
    end
    bus.MemReady = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL mw_done_ctl got=%b want=%b", ctl, CtlRun); end
    nchecks++; if (bus.StallCount !== 16'd3) begin nfail++; $display("FAIL mw_stall got=%0d want=3", bus.StallCount); end
    tick();
    nchecks++; if (bus.StallCount !== 16'd3) begin nfail++; $display("FAIL mw_stall_hold got=%0d want=3", bus.StallCount); end
    idle();
    // Branch waiting behind a memory access fires on the completing cycle
    bus.Mmemread = 1'b1; bus.MemReady = 1'b0; bus.Mbranch = 1'b1; bus.MAluZero = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlOff) begin nfail++; $display("FAIL mwbr_wait got=%b want=%b", ctl, CtlOff); end
    tick();
    bus.MemReady = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlBr) begin nfail++; $display("FAIL mwbr_fire got=%b want=%b", ctl, CtlBr); end
    tick();
    nchecks++; if (bus.FlushCount !== 16'd1) begin nfail++; $display("FAIL mwbr_flush got=%0d want=1", bus.FlushCount); end
    nchecks++; if (bus.StallCount !== 16'd4) begin nfail++; $display("FAIL mwbr_stall got=%0d want=4", bus.StallCount); end
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.Mmemwrite = 1'b1; bus.MemReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      nchecks++; if (ctl !== CtlOff) begin nfail++; $display("FAIL to_ctl[%0d] got=%b want=%b", i, ctl, CtlOff); end
      nchecks++; if (bus.MemTimeout !== 1'b0) begin nfail++; $display("FAIL to_early[%0d] got=%b want=0", i, bus.MemTimeout); end
      tick();
    end
    nchecks++; if (bus.MemTimeout !== 1'b1) begin nfail++; $display("FAIL to_flag got=%b want=1", bus.MemTimeout); end
    nchecks++; if (bus.StallCount !== 16'd16) begin nfail++; $display("FAIL to_stall got=%0d want=16", bus.StallCount); end
    // ERR ignores completion and redirects
    bus.Mmemwrite = 1'b0; bus.MemReady = 1'b1; bus.Mbranch = 1'b1; bus.MAluZero = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlOff) begin nfail++; $display("FAIL err_ctl got=%b want=%b", ctl, CtlOff); end
    tick();
    nchecks++; if (bus.FlushCount !== 16'd0) begin nfail++; $display("FAIL err_flush got=%0d want=0", bus.FlushCount); end
    nchecks++; if (bus.StallCount !== 16'd16) begin nfail++; $display("FAIL err_stall got=%0d want=16", bus.StallCount); end
    nchecks++; if (bus.MemTimeout !== 1'b1) begin nfail++; $display("FAIL err_sticky got=%b want=1", bus.MemTimeout); end
    rst = 1'b0;
    #1;
    nchecks++; if (bus.MemTimeout !== 1'b0) begin nfail++; $display("FAIL to_rst_flag got=%b want=0", bus.MemTimeout); end
    nchecks++; if (bus.StallCount !== 16'd0) begin nfail++; $display("FAIL to_rst_stall got=%0d want=0", bus.StallCount); end
    idle();
    rst = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL to_rst_run got=%b want=%b", ctl, CtlRun); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.Mmemread = 1'b1; bus.MemReady = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    nchecks++; if (ctl !== CtlOff) begin nfail++; $display("FAIL ar_ctl got=%b want=%b", ctl, CtlOff); end
    nchecks++; if (bus.StallCount !== 16'd0) begin nfail++; $display("FAIL ar_stall got=%0d want=0", bus.StallCount); end
    // Back in RUN: no pending access means all writes enabled
    bus.Mmemread = 1'b0;
    rst = 1'b1;
    #1;
    nchecks++; if (ctl !== CtlRun) begin nfail++; $display("FAIL ar_run got=%b want=%b", ctl, CtlRun); end
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_memwait();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Generates write-enable (stall) and flush controls for PC, IF/ID, ID/EX and EX/MEM (EXMRegister).
- Resolves load-use hazards, MEM-stage control redirects (branch / jr / jal) and multi-cycle data-memory waits with timeout.
- Sits beside the pipeline registers; consumes ID, EX and MEM-stage control fields.

Parameters:
REG_ADDR_W, 5, register-address width
CNT_W, 16, width of the saturating performance counters
MEM_TIMEOUT, 16, max consecutive MemReady-low cycles before the error trap (≥2)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
IDrs  in  REG_ADDR_W  rs field of the instruction in ID
IDrt  in  REG_ADDR_W  rt field of the instruction in ID
IDusesRt  in  1  ID instruction reads rt
EXmemread  in  1  ID/EX stage holds a load
EXRegDst  in  REG_ADDR_W  ID/EX destination register
Mbranch  in  1  EX/MEM branch control (Mbranch)
MAluZero  in  1  EX/MEM zero flag (MAluZero)
Mcntrljr  in  2  EX/MEM jump-register control; nonzero = jr
Mcntrljald  in  1  EX/MEM jal control
Mmemread  in  1  MEM-stage load
Mmemwrite  in  1  MEM-stage store
MemReady  in  1  data memory completes the access this cycle
PCWrite  out  1  PC load enable
IFIDWrite  out  1  IF/ID load enable
IDEXWrite  out  1  ID/EX load enable
EXMWrite  out  1  EX/MEM load enable
IFIDFlush  out  1  zero IF/ID on next edge
IDEXFlush  out  1  zero ID/EX control bits on next edge
EXMFlush  out  1  zero EX/MEM control bits on next edge
PCSrcSel  out  2  00 PC+4, 01 branch target, 10 jr target (MRD1), 11 jal target
StallCount  out  CNT_W  saturating count of stall cycles
FlushCount  out  CNT_W  saturating count of redirect events
MemTimeout  out  1  sticky error flag

Behaviour:
- FSM states: RUN, MEMWAIT, ERR. Registered state; Mealy outputs (combinational from state and inputs).
- Reset low (async): state=RUN, StallCount=0, FlushCount=0, MemTimeout=0, wait counter=0.
- While Reset is low, all Write enables=0, all Flush outputs=0, PCSrcSel=00.
- RUN defaults: all Write=1, all Flush=0, PCSrcSel=00.
- RUN priority (highest first):
  - Memory wait: (Mmemread|Mmemwrite) & !MemReady → all Write=0, no flush, no redirect this cycle; next state MEMWAIT; wait counter=1.
  - Redirect: Mcntrljr!=0 → PCSrcSel=10; else Mcntrljald → 11; else Mbranch&MAluZero → 01. Asserts IFIDFlush, IDEXFlush, EXMFlush. FlushCount+1. Any coincident load-use stall is discarded.
  - Load-use: EXmemread & EXRegDst!=0 & (EXRegDst==IDrs | (IDusesRt & EXRegDst==IDrt)) → PCWrite=0, IFIDWrite=0, IDEXFlush=1 (bubble). StallCount+1. Exactly one cycle per hazard.
- MEMWAIT:
  - All Write=0, all Flush=0, StallCount+1 per cycle.
  - Pipeline inputs stay frozen, so redirect and load-use evaluation is deferred.
  - MemReady=1 → the cycle is evaluated with full RUN rules (redirect/load-use may fire); next state RUN; wait counter cleared.
  - MemReady=0 with wait counter==MEM_TIMEOUT-1 → MemTimeout=1; next state ERR.
  - Otherwise wait counter+1.
- ERR: all Write=0, all Flush=0, counters frozen. Exit only via Reset.
- Counters saturate at all-ones; no wrap.
- Reset mid-MEMWAIT returns to RUN with counters cleared.
- Latency: all controls act on the same clock edge as the condition (zero added latency).

Decomposition:
- Shared package: state encoding constants (ST_RUN=2'd0, ST_MEMWAIT=2'd1, ST_ERR=2'd2) and PCSrcSel codes (PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_JAL).
- One sub-module: sat_counter (CNT_W, inc, async active-low clear), instantiated twice.
- Hazard and redirect detection stay inline.

Test Plan:
- Load-use: EXmemread=1, EXRegDst=8, IDrs=8 → one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount=1. Same with EXRegDst=0 → no stall.
- Branch taken: Mbranch=1, MAluZero=1 → PCSrcSel=01, all three flushes=1, FlushCount=1. Same with MAluZero=0 → PCSrcSel=00, no flush.
- Redirect priority: Mcntrljr=3, Mcntrljald=1, Mbranch=1, MAluZero=1, plus coincident load-use → PCSrcSel=10, flushes=1, StallCount unchanged.
- Memory wait: Mmemread=1, MemReady low for 3 cycles then high → all Writes=0 for 3 cycles, StallCount=3, state back to RUN, Writes=1 on the 4th cycle.
- Timeout: Mmemwrite=1, MemReady held 0 → MemTimeout=1 after 16 cycles, state ERR, Writes stay 0. Reset low → MemTimeout=0, state RUN, counters=0.
- Async reset: Reset pulled low mid-MEMWAIT, off a clock edge → outputs go to reset values immediately, without waiting for Clk.
